thermal_plant: RTL and testbench
================================

Name: thermal_plant

Overview:
- Parametrised next-generation hotplate plant model used as the closed-loop load for the digital PID controller.
- Adds the following to the fixed-rate model:
  - a programmable update-rate divider
  - thermal transport lag (a delay line on heater power)
  - temperature-proportional heat loss
  - an over-temperature interlock state machine that cuts the heater until the plate has cooled and the fault is cleared.
- Sits between the PID/PWM stage (`heater_power`) and the sensor path (`current_temp`).

Parameters:
- TEMP_W, 16, signed temperature width
- PWR_W, 8, heater power width (unsigned)
- HEATING_SHIFT, 3, heat in = power >> HEATING_SHIFT
- COOLING_RATE, 1, constant loss per update
- LOSS_SHIFT, 5, proportional loss = (temp - AMBIENT_TEMP) >>> LOSS_SHIFT
- LAG_DEPTH, 4, heater power delay stages (>=1)
- UPDATE_DIV, 1, enabled clocks per plant update (>=1)
- AMBIENT_TEMP, 25, lower clamp and reset temperature
- MAX_TEMP, 400, upper clamp
- TRIP_TEMP, 380, interlock trip threshold
- RESUME_TEMP, 300, interlock re-arm threshold
- Constraint: AMBIENT_TEMP < RESUME_TEMP < TRIP_TEMP <= MAX_TEMP.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  plant runs when 1; freezes when 0
- heater_power  in  PWR_W  requested heater drive
- fault_clr  in  1  interlock clear request (level, sampled every clock)
- heater_applied  out  PWR_W  power entering lag line (combinational: heater_power in NORMAL, 0 in TRIPPED)
- current_temp  out  TEMP_W signed  plate temperature (registered)
- temp_valid  out  1  one-cycle pulse, registered with each current_temp update
- overtemp  out  1  high while the interlock is TRIPPED

Behaviour:

Reset (reset=0, asynchronous):
- current_temp=AMBIENT_TEMP
- all lag stages=0
- divider=0
- temp_valid=0
- overtemp=0
- state=NORMAL
- Reset mid-operation discards all in-flight heat.

Divider:
- Counts 0..UPDATE_DIV-1 only while enable=1.
- tick = enable && (cnt==UPDATE_DIV-1); cnt then wraps to 0.
- enable=0 holds cnt, current_temp and the lag line; temp_valid=0.
- UPDATE_DIV=1 gives a tick every enabled cycle.

Lag line, on tick only:
- p = lag[LAG_DEPTH-1] (pre-shift value); then lag[0] <= heater_applied and lag[i] <= lag[i-1].
- Power sampled at tick t first affects current_temp at tick t+LAG_DEPTH.

Update, on tick:
- delta = (p >> HEATING_SHIFT) - COOLING_RATE - ((current_temp - AMBIENT_TEMP) >>> LOSS_SHIFT), computed signed in TEMP_W+2 bits.
- next = current_temp + delta, clamped to [AMBIENT_TEMP, MAX_TEMP].
- current_temp <= next; temp_valid <= 1 (0 on all other cycles).

Interlock FSM (2 states):
- NORMAL -> TRIPPED on the tick where next >= TRIP_TEMP. overtemp rises on the same edge as current_temp.
- TRIPPED -> NORMAL on any clock where fault_clr=1 and current_temp <= RESUME_TEMP. This clock need not be a tick.
- fault_clr while current_temp > RESUME_TEMP is ignored and not remembered.
- Trip does not flush the lag line; heat already in flight is still delivered.
- Equality counts in both directions: temp == TRIP_TEMP trips; temp == RESUME_TEMP allows clear.

Optional Feature:
- Macro: THERMAL_PLANT_NOISE_EN.
- Defined:
  - 16-bit Galois LFSR (taps 0xB400), seed 0xACE1 on reset, advances once per tick.
  - delta += (lfsr[0] ? +1 : -1) before the clamp.
- Undefined: no LFSR; behaviour fully deterministic as above.

Test Plan:
All tests use defaults unless a parameter is stated, noise disabled.
1. Reset, heater_power=0, enable=1 -> current_temp held at 25 (ambient clamp); temp_valid high every cycle after the first tick; overtemp=0.
2. Lag: step heater_power 0->160 at tick t -> current_temp stays 25 through tick t+3; after tick t+4, current_temp=44 (25+20-1-0).
3. Steady state: heater_power=80 held -> temp rises monotonically and settles at exactly 313, where delta=0. Holds there; overtemp=0.
4. Trip/clear: heater_power=255 -> overtemp=1 and heater_applied=0 on the tick temp >= 380. Temp keeps rising for up to LAG_DEPTH ticks, then decays. fault_clr pulse at temp 350 is ignored. fault_clr pulse at temp <= 300 returns to NORMAL on the next edge.
5. Divider: UPDATE_DIV=4 -> temp_valid every 4th enabled cycle. enable=0 for 3 cycles mid-count -> cnt, temp and lag line frozen; counting resumes with no lost or extra tick.
6. Reset mid-run at temp ~200 with overtemp=1 -> immediately temp=25, overtemp=0, temp_valid=0. After release with heater_power=0, temp remains 25 (lag line was cleared).

Source files
------------

// File: rtl/thermal_plant_if.sv
// Plant-side bundle between the PID/PWM stage and the sensor path.
// The master drives heater demand and clear; the plant (slave) returns temperature and status.
interface thermal_plant_if #(
  parameter int TEMP_W = 16,
  parameter int PWR_W  = 8
);
  logic                     enable;
  logic        [PWR_W-1:0]  heater_power;
  logic                     fault_clr;
  logic        [PWR_W-1:0]  heater_applied;
  logic signed [TEMP_W-1:0] current_temp;
  logic                     temp_valid;
  logic                     overtemp;

  modport master (
    output enable, heater_power, fault_clr,
    input  heater_applied, current_temp, temp_valid, overtemp
  );
  modport slave (
    input  enable, heater_power, fault_clr,
    output heater_applied, current_temp, temp_valid, overtemp
  );
endinterface

// File: rtl/thermal_plant.sv
// Hotplate plant model with an update divider, a heater transport lag and proportional loss.
// It also has an over-temperature interlock. Define THERMAL_PLANT_NOISE_EN to add +/-1 LFSR noise per update.
module thermal_plant #(
  parameter int TEMP_W        = 16,
  parameter int PWR_W         = 8,
  parameter int HEATING_SHIFT = 3,
  parameter int COOLING_RATE  = 1,
  parameter int LOSS_SHIFT    = 5,
  parameter int LAG_DEPTH     = 4,
  parameter int UPDATE_DIV    = 1,
  parameter int AMBIENT_TEMP  = 25,
  parameter int MAX_TEMP      = 400,
  parameter int TRIP_TEMP     = 380,
  parameter int RESUME_TEMP   = 300
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  thermal_plant_if.slave   bus
);
  localparam int DW = TEMP_W + 2;
  localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

  localparam logic signed [DW-1:0] AMB_X    = DW'(AMBIENT_TEMP);
  localparam logic signed [DW-1:0] MAX_X    = DW'(MAX_TEMP);
  localparam logic signed [DW-1:0] TRIP_X   = DW'(TRIP_TEMP);
  localparam logic signed [DW-1:0] RESUME_X = DW'(RESUME_TEMP);
  localparam logic signed [DW-1:0] COOL_X   = DW'(COOLING_RATE);
  localparam logic        [CW-1:0] CNT_LAST = CW'(UPDATE_DIV - 1);

  localparam logic [0:0] S_NORMAL  = 1'b0;
  localparam logic [0:0] S_TRIPPED = 1'b1;

  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [LAG_DEPTH-1:0][PWR_W-1:0] lag_q, lag_d;
  logic signed [TEMP_W-1:0]        temp_q, temp_d;
  logic                            valid_q;
  logic [0:0]                      state_q, state_d;

  logic                 tick;
  logic [PWR_W-1:0]     heat_app;
  logic [PWR_W-1:0]     p;
  logic signed [DW-1:0] temp_x, heat_x, diff_x, loss_x, noise_x, delta_x, next_x, next_c;

  assign tick     = bus.enable && (cnt_q == CNT_LAST);
  assign heat_app = (state_q == S_TRIPPED) ? '0 : bus.heater_power;
  assign p        = lag_q[LAG_DEPTH-1];

  assign temp_x  = {{2{temp_q[TEMP_W-1]}}, temp_q};
  assign heat_x  = DW'(p >> HEATING_SHIFT);
  assign diff_x  = temp_x - AMB_X;
  assign loss_x  = diff_x >>> LOSS_SHIFT;
  assign delta_x = heat_x - COOL_X - loss_x + noise_x;
  assign next_x  = temp_x + delta_x;

`ifdef THERMAL_PLANT_NOISE_EN
  logic [15:0] lfsr_q;
  assign noise_x = lfsr_q[0] ? DW'(1) : -DW'(1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)  lfsr_q <= 16'hACE1;
    else if (tick)  lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign noise_x = '0;
`endif

  always_comb begin
    next_c = next_x;
    if (next_x < AMB_X)      next_c = AMB_X;
    else if (next_x > MAX_X) next_c = MAX_X;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tick)            cnt_d = '0;
    else if (bus.enable) cnt_d = cnt_q + CW'(1);
  end

  // Oldest sample sits at the top index; p is read before the shift on the same tick.
  always_comb begin
    lag_d  = lag_q;
    temp_d = temp_q;
    if (tick) begin
      lag_d[0] = heat_app;
      for (int i = 1; i < LAG_DEPTH; i++) lag_d[i] = lag_q[i-1];
      temp_d = next_c[TEMP_W-1:0];
    end
  end

  // Clear is evaluated every clock against the registered temperature, not just on ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORMAL:  if (tick && next_c >= TRIP_X) state_d = S_TRIPPED;
      S_TRIPPED: if (bus.fault_clr && temp_x <= RESUME_X) state_d = S_NORMAL;
      default:   state_d = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      lag_q   <= '0;
      temp_q  <= TEMP_W'(AMBIENT_TEMP);
      valid_q <= 1'b0;
      state_q <= S_NORMAL;
    end else begin
      cnt_q   <= cnt_d;
      lag_q   <= lag_d;
      temp_q  <= temp_d;
      valid_q <= tick;
      state_q <= state_d;
    end
  end

  assign bus.heater_applied = heat_app;
  assign bus.current_temp   = temp_q;
  assign bus.temp_valid     = valid_q;
  assign bus.overtemp       = (state_q == S_TRIPPED);
endmodule

// File: tb/tb_thermal_plant.sv
// Bench for thermal_plant: two instances (update divider 1 and 4) share random and directed stimulus.
// Each instance is compared every clock against a behavioural plant model.
module tb_thermal_plant;
  localparam int LAG = 4;

  typedef struct {
    int temp;
    int cnt;
    bit trip;
    bit valid;
    int lag[LAG];
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  thermal_plant_if ifa ();
  thermal_plant_if ifb ();

  thermal_plant #(.UPDATE_DIV(1)) dut_a (.clk_i(clk), .reset_ni(rst_n), .bus(ifa));
  thermal_plant #(.UPDATE_DIV(4)) dut_b (.clk_i(clk), .reset_ni(rst_n), .bus(ifb));

  function automatic mdl_t mreset();
    mdl_t m;
    m.temp = 25; m.cnt = 0; m.trip = 0; m.valid = 0;
    foreach (m.lag[i]) m.lag[i] = 0;
    return m;
  endfunction

  // lag[LAG-1] holds the power sampled LAG ticks ago.
  function automatic mdl_t mstep(mdl_t m, int div, bit en, int pwr, bit fc);
    mdl_t n = m;
    int applied, nt;
    bit tick;
    applied = m.trip ? 0 : pwr;
    tick = en && (m.cnt == div - 1);
    n.valid = tick;
    if (en) n.cnt = tick ? 0 : m.cnt + 1;
    if (tick) begin
      nt = m.temp + m.lag[LAG-1] / 8 - 1 - (m.temp - 25) / 32;
      if (nt < 25) nt = 25;
      if (nt > 400) nt = 400;
      for (int i = LAG - 1; i > 0; i--) n.lag[i] = m.lag[i-1];
      n.lag[0] = applied;
      n.temp = nt;
      if (!m.trip && nt >= 380) n.trip = 1;
    end
    if (m.trip && fc && m.temp <= 300) n.trip = 0;
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("a_temp",  int'(ifa.current_temp), ma.temp);
    chk("a_valid", int'(ifa.temp_valid),   int'(ma.valid));
    chk("a_otemp", int'(ifa.overtemp),     int'(ma.trip));
    chk("b_temp",  int'(ifb.current_temp), mb.temp);
    chk("b_valid", int'(ifb.temp_valid),   int'(mb.valid));
    chk("b_otemp", int'(ifb.overtemp),     int'(mb.trip));
  endtask

  // Drive inputs, check the combinational heater path, clock once, check registered outputs.
  task automatic cyc(input bit en, input int pwr, input bit fc);
    ifa.enable = en; ifa.heater_power = 8'(pwr); ifa.fault_clr = fc;
    ifb.enable = en; ifb.heater_power = 8'(pwr); ifb.fault_clr = fc;
    #1;
    chk("a_applied", int'(ifa.heater_applied), ma.trip ? 0 : pwr);
    chk("b_applied", int'(ifb.heater_applied), mb.trip ? 0 : pwr);
    @(posedge clk);
    ma = mstep(ma, 1, en, pwr, fc);
    mb = mstep(mb, 4, en, pwr, fc);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    ma = mreset(); mb = mreset();
    check_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    ifa.enable = 0; ifa.heater_power = 0; ifa.fault_clr = 0;
    ifb.enable = 0; ifb.heater_power = 0; ifb.fault_clr = 0;
    ma = mreset(); mb = mreset();
    @(posedge clk);
    do_reset();

    // Idle with zero drive: ambient clamp holds
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    chk("idle_ambient", int'(ifa.current_temp), 25);

    // Lag: step to 160, first heat visible on the fifth tick
    for (int i = 0; i < 4; i++) cyc(1, 160, 0);
    chk("lag_hold", int'(ifa.current_temp), 25);
    cyc(1, 160, 0);
    chk("lag_first", int'(ifa.current_temp), 44);
    for (int i = 0; i < 10; i++) cyc(1, 160, 0);

    // Steady state at 80
    for (int i = 0; i < 400; i++) cyc(1, 80, 0);
    chk("steady", int'(ifa.current_temp), 313);
    cyc(1, 80, 0);
    chk("steady_hold", int'(ifa.current_temp), 313);

    // Drive hard until trip
    n = 0;
    while (!ifa.overtemp && n < 300) begin cyc(1, 255, 0); n++; end
    chk("trip_seen", int'(ifa.overtemp), 1);
    chk("trip_applied", int'(ifa.heater_applied), 0);
    chk("trip_thresh", int'(ifa.current_temp >= 380), 1);
    // Wait for decay into the 301..379 band, then try an early clear
    n = 0;
    while ((ifa.current_temp > 360 || ifa.current_temp <= 300) && n < 100) begin
      cyc(1, $urandom_range(255), 0); n++;
    end
    chk("band_reached", int'(ifa.current_temp > 300 && ifa.current_temp <= 360), 1);
    cyc(1, 255, 1);
    chk("early_clr_ignored", int'(ifa.overtemp), 1);
    n = 0;
    while (ifa.current_temp > 300 && n < 100) begin cyc(1, 255, 0); n++; end
    chk("resume_reached", int'(ifa.current_temp <= 300), 1);
    cyc(0, 0, 1);
    chk("clear_ok", int'(ifa.overtemp), 0);

    // Random operation with enable gaps and sporadic clears
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(9) < 7, $urandom_range(255), $urandom_range(9) == 0);

    // Directed freeze of the divide-by-4 instance mid-count
    for (int i = 0; i < 6; i++) cyc(1, 100, 0);
    for (int i = 0; i < 3; i++) cyc(0, 200, 0);
    for (int i = 0; i < 8; i++) cyc(1, 100, 0);

    // Heat to trip, decay to about 200, then reset while tripped
    for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    n = 0;
    while (!ifa.overtemp && n < 400) begin cyc(1, 255, 0); n++; end
    chk("retrip", int'(ifa.overtemp), 1);
    n = 0;
    while (ifa.current_temp > 200 && n < 200) begin cyc(1, 0, 0); n++; end
    chk("mid_overtemp", int'(ifa.overtemp), 1);
    do_reset();
    chk("rst_temp", int'(ifa.current_temp), 25);
    chk("rst_otemp", int'(ifa.overtemp), 0);
    chk("rst_valid", int'(ifa.temp_valid), 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    chk("post_rst_cold", int'(ifa.current_temp), 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
